// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage and its neighbours.
// Holds the IF/ID bundle layout, the NOP encoding, PC step and target alignment.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = '0;

    localparam int unsigned PC_INC = 4;

    // Low address bits cleared on a branch target.
    localparam int unsigned ALIGN_BITS = 3;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Unsigned up-counter that saturates at all-ones; cleared only by reset.
// Ports: clk, rst (async active-low), inc (count enable), count (value).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic             w_full;

    assign w_full = &r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && !w_full) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register; branch > freeze > advance each edge.
// Ports: clk, rst (async low), freeze, branch_taken/addr, imem_addr/rdata,
//        if_id_instr/pc/valid, pc (debug), stall_cnt, flush_cnt.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter int              CNT_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic [ADDR_W-1:0] r_pc;
    if_id_t            r_if_id;

    logic [ADDR_W-1:0] w_pc_seq;
    logic [ADDR_W-1:0] w_br_target;
    logic              w_stall;

    assign w_pc_seq    = r_pc + ADDR_W'(PC_INC);
    assign w_br_target = branch_addr & ~ADDR_W'(ALIGN_BITS);

    // A freeze coinciding with a branch is moot: the held slot is squashed.
    assign w_stall = freeze & ~branch_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_if_id <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
        end else begin
            unique case (1'b1)
                branch_taken: begin
                    r_pc    <= w_br_target;
                    r_if_id <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
                end
                w_stall: begin
                    r_pc    <= r_pc;
                    r_if_id <= r_if_id;
                end
                default: begin
                    r_pc          <= w_pc_seq;
                    r_if_id.instr <= imem_rdata;
                    r_if_id.pc    <= w_pc_seq;
                    r_if_id.valid <= 1'b1;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign if_id_instr = r_if_id.instr;
    assign if_id_pc    = r_if_id.pc;
    assign if_id_valid = r_if_id.valid;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_taken),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: advance, freeze, branch, wrap,
// counter saturation and asynchronous reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic [31:0] pc;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic [31:0] imem_addr4;
    logic [31:0] imem_rdata4;
    logic [31:0] if_id_instr4;
    logic [31:0] if_id_pc4;
    logic        if_id_valid4;
    logic [31:0] pc4;
    logic [3:0]  stall_cnt4;
    logic [3:0]  flush_cnt4;

    int checks;
    int failures;

    assign imem_rdata  = 32'hE000_0000 + imem_addr;
    assign imem_rdata4 = 32'hE000_0000 + imem_addr4;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_valid  (if_id_valid),
        .pc           (pc),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    fetch_stage #(
        .CNT_W (4)
    ) dut4 (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr4),
        .imem_rdata   (imem_rdata4),
        .if_id_instr  (if_id_instr4),
        .if_id_pc     (if_id_pc4),
        .if_id_valid  (if_id_valid4),
        .pc           (pc4),
        .stall_cnt    (stall_cnt4),
        .flush_cnt    (flush_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        #12;
        checks++;
        if ({pc, if_id_instr, if_id_pc} !== 96'h0 || if_id_valid !== 1'b0 ||
            stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: pc=%h instr=%h ipc=%h v=%b sc=%0d fc=%0d",
                     pc, if_id_instr, if_id_pc, if_id_valid, stall_cnt, flush_cnt);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h4 || if_id_instr !== 32'hE000_0000 ||
            if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_fetch: pc=%h instr=%h ipc=%h v=%b want 4 E0000000 4 1",
                     pc, if_id_instr, if_id_pc, if_id_valid);
        end
        tick();
        checks++;
        if (pc !== 32'h8 || if_id_instr !== 32'hE000_0004 ||
            if_id_pc !== 32'h8 || if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL second_fetch: pc=%h instr=%h ipc=%h v=%b want 8 E0000004 8 1",
                     pc, if_id_instr, if_id_pc, if_id_valid);
        end
        tick();
        tick();
        checks++;
        if (pc !== 32'h10 || if_id_instr !== 32'hE000_000C || if_id_pc !== 32'h10) begin
            failures++;
            $display("FAIL fetch_to_10: pc=%h instr=%h ipc=%h want 10 E000000C 10",
                     pc, if_id_instr, if_id_pc);
        end
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc !== 32'h10 || if_id_instr !== 32'hE000_000C ||
                if_id_pc !== 32'h10 || if_id_valid !== 1'b1 ||
                stall_cnt !== 16'(i)) begin
                failures++;
                $display("FAIL freeze_hold_%0d: pc=%h instr=%h ipc=%h v=%b sc=%0d want 10 E000000C 10 1 %0d",
                         i, pc, if_id_instr, if_id_pc, if_id_valid, stall_cnt, i);
            end
        end
        freeze = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h14 || if_id_instr !== 32'hE000_0010 ||
            if_id_pc !== 32'h14 || stall_cnt !== 16'd3) begin
            failures++;
            $display("FAIL freeze_release: pc=%h instr=%h ipc=%h sc=%0d want 14 E0000010 14 3",
                     pc, if_id_instr, if_id_pc, stall_cnt);
        end
    endtask

    task automatic test_branch_freeze();
        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h103;
        tick();
        freeze       = 1'b0;
        branch_taken = 1'b0;
        checks++;
        if (pc !== 32'h100 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0 ||
            if_id_valid !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd3) begin
            failures++;
            $display("FAIL branch_edge: pc=%h instr=%h ipc=%h v=%b fc=%0d sc=%0d want 100 0 0 0 1 3",
                     pc, if_id_instr, if_id_pc, if_id_valid, flush_cnt, stall_cnt);
        end
        tick();
        checks++;
        if (pc !== 32'h104 || if_id_instr !== 32'hE000_0100 ||
            if_id_pc !== 32'h104 || if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL branch_target: pc=%h instr=%h ipc=%h v=%b want 104 E0000100 104 1",
                     pc, if_id_instr, if_id_pc, if_id_valid);
        end
    endtask

    task automatic test_bubble_freeze();
        branch_taken = 1'b1;
        branch_addr  = 32'h201;
        tick();
        branch_taken = 1'b0;
        freeze       = 1'b1;
        tick();
        tick();
        checks++;
        if (pc !== 32'h200 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
            stall_cnt !== 16'd5 || flush_cnt !== 16'd2) begin
            failures++;
            $display("FAIL bubble_frozen: pc=%h v=%b instr=%h sc=%0d fc=%0d want 200 0 0 5 2",
                     pc, if_id_valid, if_id_instr, stall_cnt, flush_cnt);
        end
        freeze = 1'b0;
        tick();
        checks++;
        if (if_id_instr !== 32'hE000_0200 || if_id_pc !== 32'h204 ||
            if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL bubble_release: instr=%h ipc=%h v=%b want E0000200 204 1",
                     if_id_instr, if_id_pc, if_id_valid);
        end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFE;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (pc !== 32'hFFFF_FFFC || flush_cnt !== 16'd3) begin
            failures++;
            $display("FAIL wrap_target: pc=%h fc=%0d want FFFFFFFC 3", pc, flush_cnt);
        end
        tick();
        checks++;
        if (pc !== 32'h0 || if_id_pc !== 32'h0 || if_id_instr !== 32'hDFFF_FFFC ||
            if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_advance: pc=%h ipc=%h instr=%h v=%b want 0 0 DFFFFFFC 1",
                     pc, if_id_pc, if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_saturate();
        #2;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        freeze = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15 || i == 20) begin
                checks++;
                if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'(i) || pc4 !== 32'h0) begin
                    failures++;
                    $display("FAIL saturate_%0d: sc4=%0d sc=%0d pc4=%h want 15 %0d 0",
                             i, stall_cnt4, stall_cnt, pc4, i);
                end
            end
        end
        freeze = 1'b0;
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        tick();
        freeze = 1'b1;
        tick();
        tick();
        checks++;
        if (pc !== 32'hC || stall_cnt !== 16'd22 || if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_async: pc=%h sc=%0d v=%b want C 22 1",
                     pc, stall_cnt, if_id_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({pc, if_id_instr, if_id_pc} !== 96'h0 || if_id_valid !== 1'b0 ||
            stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: pc=%h instr=%h ipc=%h v=%b sc=%0d fc=%0d",
                     pc, if_id_instr, if_id_pc, if_id_valid, stall_cnt, flush_cnt);
        end
        freeze = 1'b0;
        #3;
        rst = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h4 || if_id_instr !== 32'hE000_0000 ||
            if_id_pc !== 32'h4 || if_id_valid !== 1'b1 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL async_resume: pc=%h instr=%h ipc=%h v=%b sc=%0d want 4 E0000000 4 1 0",
                     pc, if_id_instr, if_id_pc, if_id_valid, stall_cnt);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_freeze();
        test_branch_freeze();
        test_bubble_freeze();
        test_wrap();
        test_saturate();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
